pool_window_sequencer: RTL and testbench

Controller that streams one feature-map channel, row-major, into the pooling line buffer (RAM-based shift register, 256 words deep). It generates the buffer's write enable, delay length and clear pulse, and tracks row and column position. It flags each cycle on which the incoming pixel plus the buffer output form a complete 2x2 pooling window. It sits between the feature-map read stream and the pool compare datapath, one instance per line buffer.

---
 rtl/pool_window_sequencer_pkg.sv | 30 +++
 rtl/pool_window_sequencer_if.sv | 44 ++++
 rtl/pool_pos_counter.sv | 67 ++++++
 rtl/pool_window_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_pool_window_sequencer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pool_window_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pool_window_sequencer_pkg
// Description : Shared constants for the pooling line-buffer slice: sequencer
//               state encoding, line-buffer depth and the configuration
//               legality helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pool_window_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Depth of the RAM-based shift register in the line buffer; a row must fit.
  localparam int unsigned LB_DEPTH = 256;
  localparam int unsigned MIN_DIM  = 2;
  localparam int unsigned MAX_ROWS = 1023;

  // A channel is legal when both dimensions allow at least one 2x2 window
  // and a full row fits in the line buffer.
  function automatic logic cfg_legal(input int unsigned w, input int unsigned h);
    return (w >= MIN_DIM) && (w <= LB_DEPTH) && (h >= MIN_DIM) && (h <= MAX_ROWS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pool_window_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pool_window_sequencer_if
// Description : Control, stream handshake and line-buffer signals of the
//               pooling window sequencer.
//               master : drives start/abort/config/in_valid (stream source)
//               slave  : the sequencer itself
// Revision    : 1.0 - initial release
// ============================================================================
interface pool_window_sequencer_if #(
  parameter int COL_W = 10
);
  import pool_window_sequencer_pkg::*;

  logic             start;
  logic             abort;
  logic [COL_W-1:0] cfg_col_size;
  logic [COL_W-1:0] cfg_row_size;
  logic             cfg_stride2;
  logic             in_valid;
  logic             in_ready;
  logic             lb_wr_en;
  logic [COL_W-1:0] lb_col_size;
  logic             lb_ram_rst;
  logic             win_valid;
  logic             win_last;
  logic             busy;
  logic             done;
  logic             cfg_err;

  modport master (
    output start, abort, cfg_col_size, cfg_row_size, cfg_stride2, in_valid,
    input  in_ready, lb_wr_en, lb_col_size, lb_ram_rst, win_valid, win_last,
           busy, done, cfg_err
  );

  modport slave (
    input  start, abort, cfg_col_size, cfg_row_size, cfg_stride2, in_valid,
    output in_ready, lb_wr_en, lb_col_size, lb_ram_rst, win_valid, win_last,
           busy, done, cfg_err
  );

endinterface
`default_nettype wire

// File: rtl/pool_pos_counter.sv
`default_nettype none
// ============================================================================
// Module      : pool_pos_counter
// Description : Row-major column/row position counter for one channel.
//               col wraps at col_max and then advances row; row wraps at
//               row_max. clr has priority over adv.
// Ports       : system_clk, rst_n (async, active-low)
//               clr      - zero both counters
//               adv      - advance one pixel
//               col_max  - W-1, row_max - H-1
//               col,row  - position of the pixel currently presented
//               col_last, row_last - position is at the end of row / channel
// Revision    : 1.0 - initial release
// ============================================================================
module pool_pos_counter
  import pool_window_sequencer_pkg::*;
#(
  parameter int COL_W = 10
) (
  input  logic             system_clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  input  logic [COL_W-1:0] col_max,
  input  logic [COL_W-1:0] row_max,
  output logic [COL_W-1:0] col,
  output logic [COL_W-1:0] row,
  output logic             col_last,
  output logic             row_last
);

  logic [COL_W-1:0] col_q, col_d;
  logic [COL_W-1:0] row_q, row_d;

  assign col_last = (col_q == col_max);
  assign row_last = (row_q == row_max);
  assign col      = col_q;
  assign row      = row_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (adv) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pool_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pool_window_sequencer
// Description : Streams one feature-map channel (row-major) into the pooling
//               line buffer. Drives the buffer write enable, delay length and
//               clear pulse, and flags cycles on which a complete 2x2 pooling
//               window is available (stride 1 or stride 2).
// Ports       : system_clk, rst_n (async, active-low)
//               bus (slave modport of pool_window_sequencer_if):
//                 start/abort, cfg_col_size/cfg_row_size/cfg_stride2,
//                 in_valid/in_ready, lb_wr_en/lb_col_size/lb_ram_rst,
//                 win_valid/win_last, busy/done/cfg_err
// Options     : POOL_SEQ_CFG_CHECK_EN - check W/H on start and report illegal
//               configurations on cfg_err; otherwise cfg_err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module pool_window_sequencer
  import pool_window_sequencer_pkg::*;
#(
  parameter int COL_W      = 10,
  parameter int CLR_CYCLES = 4
) (
  input  logic                    system_clk,
  input  logic                    rst_n,
  pool_window_sequencer_if.slave  bus
);

  localparam int               CLR_W    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [COL_W-1:0] col_size_q, col_size_d;
  logic [COL_W-1:0] row_size_q, row_size_d;
  logic             stride2_q, stride2_d;
  logic             win_valid_q, win_valid_d;
  logic             win_last_q, win_last_d;
  logic             abort_rst_q, abort_rst_d;

  logic             cfg_ok;
  logic             start_seen;
  logic             start_ok;
  logic             aborting;
  logic             run;
  logic             handshake;
  logic [COL_W-1:0] col_max, row_max;
  logic [COL_W-1:0] col, row;
  logic             col_last, row_last;
  logic [COL_W:0]   col_p1, row_p1;
  logic             win_hit, win_col_last, win_row_last;

`ifdef POOL_SEQ_CFG_CHECK_EN
  assign cfg_ok = cfg_legal(32'(bus.cfg_col_size), 32'(bus.cfg_row_size));
`else
  assign cfg_ok = 1'b1;
`endif

  // abort beats start; start is only honoured from IDLE
  assign aborting   = bus.abort & (state_q != ST_IDLE);
  assign start_seen = bus.start & ~bus.abort & (state_q == ST_IDLE);
  assign start_ok   = start_seen & cfg_ok;
  assign run        = (state_q == ST_RUN);
  assign handshake  = bus.in_valid & run;

  assign col_max = col_size_q - 1'b1;
  assign row_max = row_size_q - 1'b1;

  pool_pos_counter #(
    .COL_W (COL_W)
  ) u_pos (
    .system_clk (system_clk),
    .rst_n      (rst_n),
    .clr        (start_ok),
    .adv        (handshake),
    .col_max    (col_max),
    .row_max    (row_max),
    .col        (col),
    .row        (row),
    .col_last   (col_last),
    .row_last   (row_last)
  );

  // Stride 2 only produces windows on odd positions, so the last window
  // column is the odd one in {W-2, W-1}; testing pos >= W-2 (pos+1 >= W-1)
  // together with the odd check picks it without a parity case split.
  assign col_p1       = {1'b0, col} + 1'b1;
  assign row_p1       = {1'b0, row} + 1'b1;
  assign win_hit      = stride2_q ? (row[0] & col[0]) : ((row != '0) && (col != '0));
  assign win_col_last = stride2_q ? (col_p1 >= {1'b0, col_max}) : col_last;
  assign win_row_last = stride2_q ? (row_p1 >= {1'b0, row_max}) : row_last;

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    col_size_d  = col_size_q;
    row_size_d  = row_size_q;
    stride2_d   = stride2_q;
    win_valid_d = 1'b0;
    win_last_d  = 1'b0;
    abort_rst_d = aborting;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d    = ST_CLEAR;
          clr_cnt_d  = '0;
          col_size_d = bus.cfg_col_size;
          row_size_d = bus.cfg_row_size;
          stride2_d  = bus.cfg_stride2;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_q == CLR_LAST) begin
          state_d = ST_RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (handshake) begin
          // registered so the flag lines up with the line-buffer read data
          win_valid_d = win_hit;
          win_last_d  = win_hit & win_row_last & win_col_last;
          if (col_last && row_last) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (aborting) begin
      state_d     = ST_IDLE;
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      clr_cnt_q   <= '0;
      col_size_q  <= '0;
      row_size_q  <= '0;
      stride2_q   <= 1'b0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      abort_rst_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      col_size_q  <= col_size_d;
      row_size_q  <= row_size_d;
      stride2_q   <= stride2_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      abort_rst_q <= abort_rst_d;
    end
  end

`ifdef POOL_SEQ_CFG_CHECK_EN
  logic cfg_err_q, cfg_err_d;

  // sticky until the next start that is actually evaluated
  always_comb begin
    cfg_err_d = cfg_err_q;
    if (start_seen) begin
      cfg_err_d = ~cfg_ok;
    end
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
    end
  end

  assign bus.cfg_err = cfg_err_q;
`else
  assign bus.cfg_err = 1'b0;
`endif

  assign bus.in_ready    = run;
  assign bus.lb_wr_en    = handshake;
  assign bus.lb_col_size = col_size_q;
  assign bus.lb_ram_rst  = (state_q == ST_CLEAR) | abort_rst_q;
  assign bus.win_valid   = win_valid_q;
  assign bus.win_last    = win_last_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pool_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pool_window_sequencer
// Description : Self-checking bench for pool_window_sequencer. Channel runs
//               come from a table; expected windows are pushed to a queue as
//               pixels are accepted and popped when win_valid appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pool_window_sequencer;
  import pool_window_sequencer_pkg::*;

  localparam int COL_W      = 10;
  localparam int CLR_CYCLES = 4;

  typedef struct {
    int cyc;
    bit last;
  } exp_win_t;

  typedef struct {
    int w;
    int h;
    bit s2;
    bit gaps;
    int exp_wins;
    bit poke;
    int abort_after;
  } vec_t;

  logic system_clk = 1'b0;
  logic rst_n      = 1'b0;
  int   errors     = 0;
  int   checks     = 0;
  int   cyc        = 0;
  int   win_seen   = 0;
  exp_win_t sb[$];
  vec_t tbl[7];

  always #5 system_clk = ~system_clk;

  pool_window_sequencer_if #(.COL_W(COL_W)) bus ();

  pool_window_sequencer #(
    .COL_W      (COL_W),
    .CLR_CYCLES (CLR_CYCLES)
  ) dut (
    .system_clk (system_clk),
    .rst_n      (rst_n),
    .bus        (bus)
  );

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  initial forever begin
    @(posedge system_clk);
    cyc++;
  end

  // scoreboard consumer
  initial forever begin
    exp_win_t e;
    @(negedge system_clk);
    if (rst_n) begin
      if (bus.win_valid) begin
        win_seen++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL win_unexpected: got win_valid, expected none (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("win_cycle", cyc, e.cyc);
          check("win_last", bus.win_last, e.last);
        end
      end else begin
        check("win_last_idle", bus.win_last, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_channel(input vec_t v);
    int r = 0, c = 0, n = 0, budget = 0, clr = 0, lr, lc, target;
    bit iv = 1'b1;
    exp_win_t e;
    win_seen = 0;
    bus.cfg_col_size = COL_W'(v.w);
    bus.cfg_row_size = COL_W'(v.h);
    bus.cfg_stride2  = v.s2;
    bus.start        = 1'b1;
    @(negedge system_clk);
    bus.start = 1'b0;
    check("busy_rise", bus.busy, 1);
    while (!bus.in_ready && budget < CLR_CYCLES + 8) begin
      if (bus.lb_ram_rst) clr++;
      budget++;
      @(negedge system_clk);
    end
    check("clear_len", clr, CLR_CYCLES);
    check("ready_latency", budget, CLR_CYCLES);

    lr = v.s2 ? ((v.h % 2 == 0) ? v.h - 1 : v.h - 2) : v.h - 1;
    lc = v.s2 ? ((v.w % 2 == 0) ? v.w - 1 : v.w - 2) : v.w - 1;
    target = (v.abort_after > 0) ? v.abort_after : v.w * v.h;
    budget = 0;
    while (n < target && budget < 4 * v.w * v.h + 20) begin
      bus.in_valid = iv;
      if (v.poke && n == 5) begin
        bus.start        = 1'b1;
        bus.cfg_col_size = COL_W'(v.w + 3);
        bus.cfg_row_size = COL_W'(2);
        bus.cfg_stride2  = ~v.s2;
      end else begin
        bus.start = 1'b0;
      end
      #1;
      check("in_ready_run", bus.in_ready, 1);
      check("lb_wr_en", bus.lb_wr_en, iv);
      check("lb_col_size", bus.lb_col_size, v.w);
      if (iv) begin
        if (v.s2 ? (r % 2 == 1 && c % 2 == 1) : (r >= 1 && c >= 1)) begin
          e.cyc  = cyc + 1;
          e.last = (r == lr && c == lc);
          sb.push_back(e);
        end
        n++;
        c++;
        if (c == v.w) begin
          c = 0;
          r++;
        end
      end
      if (v.gaps) iv = ~iv;
      budget++;
      @(negedge system_clk);
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    check("pixels_sent", n, target);

    if (v.abort_after > 0) begin
      bus.abort = 1'b1;
      @(negedge system_clk);
      bus.abort = 1'b0;
      check("abort_busy", bus.busy, 0);
      check("abort_lb_rst", bus.lb_ram_rst, 1);
      check("abort_done", bus.done, 0);
      check("abort_ready", bus.in_ready, 0);
      @(negedge system_clk);
      check("abort_lb_rst_end", bus.lb_ram_rst, 0);
      check("abort_done2", bus.done, 0);
    end else begin
      check("done_pulse", bus.done, 1);
      check("busy_at_done", bus.busy, 1);
      @(negedge system_clk);
      check("busy_fall", bus.busy, 0);
      check("done_end", bus.done, 0);
    end
    check("win_count", win_seen, v.exp_wins);
    check("sb_empty", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    tbl[0] = '{w: 4, h: 4, s2: 1'b1, gaps: 1'b0, exp_wins: 4,  poke: 1'b0, abort_after: 0};
    tbl[1] = '{w: 3, h: 3, s2: 1'b0, gaps: 1'b1, exp_wins: 4,  poke: 1'b0, abort_after: 0};
    tbl[2] = '{w: 5, h: 5, s2: 1'b1, gaps: 1'b0, exp_wins: 4,  poke: 1'b0, abort_after: 0};
    tbl[3] = '{w: 8, h: 8, s2: 1'b0, gaps: 1'b0, exp_wins: 0,  poke: 1'b0, abort_after: 7};
    tbl[4] = '{w: 8, h: 8, s2: 1'b0, gaps: 1'b0, exp_wins: 49, poke: 1'b0, abort_after: 0};
    tbl[5] = '{w: 6, h: 4, s2: 1'b1, gaps: 1'b1, exp_wins: 6,  poke: 1'b1, abort_after: 0};
    tbl[6] = '{w: 4, h: 3, s2: 1'b0, gaps: 1'b0, exp_wins: 6,  poke: 1'b0, abort_after: 0};

    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.cfg_col_size = '0;
    bus.cfg_row_size = '0;
    bus.cfg_stride2  = 1'b0;
    bus.in_valid     = 1'b0;
    repeat (3) @(negedge system_clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_lb_wr_en", bus.lb_wr_en, 0);
    check("rst_win_valid", bus.win_valid, 0);
    check("rst_win_last", bus.win_last, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_cfg_err", bus.cfg_err, 0);
    check("rst_lb_ram_rst", bus.lb_ram_rst, 0);
    check("rst_lb_col_size", bus.lb_col_size, 0);
    rst_n = 1'b1;
    @(negedge system_clk);

    // start and abort together from IDLE: nothing happens
    bus.cfg_col_size = COL_W'(4);
    bus.cfg_row_size = COL_W'(4);
    bus.start        = 1'b1;
    bus.abort        = 1'b1;
    @(negedge system_clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_abort_busy", bus.busy, 0);
    check("start_abort_lb_rst", bus.lb_ram_rst, 0);
    @(negedge system_clk);

    for (int i = 0; i < 7; i++) begin
      run_channel(tbl[i]);
      repeat (2) @(negedge system_clk);
    end

`ifdef POOL_SEQ_CFG_CHECK_EN
    bus.cfg_col_size = '0;
    bus.cfg_row_size = COL_W'(4);
    bus.start        = 1'b1;
    @(negedge system_clk);
    bus.start = 1'b0;
    check("cfg_err_set", bus.cfg_err, 1);
    check("cfg_err_busy", bus.busy, 0);
    check("cfg_err_lb_rst", bus.lb_ram_rst, 0);
    @(negedge system_clk);
    check("cfg_err_sticky", bus.cfg_err, 1);
    check("cfg_err_busy2", bus.busy, 0);
    run_channel(tbl[0]);
    check("cfg_err_cleared", bus.cfg_err, 0);
`else
    check("cfg_err_tied", bus.cfg_err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
